chimp_take2_control: RTL
========================

Name: chimp_take2_control

Overview:
Sequencing FSM for the 8x8 chimp-test board datapath. It clears the board, drives the per-round load with an on-chip LFSR, and controls show/hide of the numbers. It forwards mouse clicks, judges each click from the datapath's correct/wrong flags, and manages level, strikes, score and game over.
It sits between the mouse/box-decode logic and the board datapath; the VGA renderer consumes the board plus oGameOver/oScore.

Parameters:
START_LEVEL, 4, count of numbers placed in the first round (1..MAX_LEVEL)
MAX_LEVEL, 20, level saturation ceiling (<=31, 5-bit)
MAX_STRIKES, 3, failed rounds allowed before game over
RESULT_CYCLES, 25000000, hold time of the WIN/FAIL states (0.5 s at 50 MHz)
LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
clk  in  1  system clock; single clock domain
iReset  in  1  synchronous, active-high reset
iStart  in  1  one-cycle pulse; starts a game from IDLE or GAME_OVER
iMouseClick  in  1  one-cycle click pulse, box already decoded
iDoneLoad  in  1  datapath: all numbers placed
iChoseCorrectNum  in  1  datapath correct flag (level; sticky allowed)
iChoseWrongNum  in  1  datapath wrong flag (level; sticky allowed)
oResetBoard  out  1  clear datapath board/flags
oLoadEnable  out  1  datapath may place a number this cycle
oShowEnable  out  1  numbers visible
oLevel  out  5  numbers in the current round
oNumToChoose  out  5  next number expected
oRandNum  out  8  {2'b00, row[2:0], col[2:0]} from LFSR
oMouseClick  out  1  gated click forwarded to datapath
oStrikes  out  2  failed rounds so far
oScore  out  5  highest level completed
oGameOver  out  1  high in GAME_OVER
oState  out  4  current state encoding, for debug/HEX display

Behaviour:
- All outputs are registered. On iReset:
  - state=IDLE; oResetBoard=1; oLoadEnable=0; oShowEnable=0; oMouseClick=0.
  - oLevel=START_LEVEL; oNumToChoose=1; oStrikes=0; oScore=0; oGameOver=0; LFSR=LFSR_SEED.
  - Reset mid-round aborts immediately; the in-flight click is dropped.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle, including IDLE. oRandNum[7:6]=0 and oRandNum[5:0]=LFSR[5:0].
- IDLE:
  - oResetBoard=1.
  - On iStart: oLevel=START_LEVEL, oStrikes=0, oScore=0, then go to CLEAR.
- CLEAR: exactly 1 cycle with oResetBoard=1; oNumToChoose=1; then go to LOAD.
- LOAD:
  - oResetBoard=0; oLoadEnable=1 every cycle. The datapath rejects occupied cells; the LFSR keeps supplying new cells.
  - When iDoneLoad=1: oLoadEnable=0 on the next edge, go to SHOW.
  - oLevel is stable throughout LOAD.
- SHOW / HIDE: both are "armed" states.
  - SHOW drives oShowEnable=1; HIDE drives oShowEnable=0.
  - A click in either state gives oMouseClick=1 for exactly 1 cycle, then WAIT.
- WAIT: 1 cycle, no forwarding; allows the datapath flag register to update. Then CHECK.
- CHECK: evaluates in 1 cycle, in this priority order:
  - iChoseWrongNum=1 → FAIL. Wrong takes priority if both flags are high.
  - iChoseCorrectNum=1 and oNumToChoose==oLevel → WIN.
  - iChoseCorrectNum=1 otherwise → oNumToChoose+1, oShowEnable=0, go to HIDE. The numbers hide after the first correct pick.
  - Neither flag set → FAIL. This is a protective default.
- WIN:
  - On entry: oScore=max(oScore,oLevel); oLevel=min(oLevel+1,MAX_LEVEL).
  - Hold RESULT_CYCLES, then CLEAR.
- FAIL:
  - On entry: oStrikes+1.
  - Hold RESULT_CYCLES.
  - If oStrikes==MAX_STRIKES → GAME_OVER; else → CLEAR with oLevel unchanged.
- GAME_OVER: oGameOver=1, oResetBoard=0 (board stays visible). iStart behaves as from IDLE.
- Clicks outside SHOW/HIDE are ignored. A click coincident with a state entry into SHOW is ignored; the first eligible cycle is the one after entry.
- The hold counter is 25 bits and is cleared on every state entry.

Optional Feature:
CHIMP_SHOW_TIMEOUT_EN:
- Defined: SHOW additionally counts SHOW_CYCLES (localparam = 2*RESULT_CYCLES). On expiry with no click, go to HIDE (oShowEnable=0), still waiting for "1".
- Undefined: numbers stay visible until the first correct click.

Test Plan:
- Reset with LFSR_SEED=8'hA5 → oResetBoard=1, oLevel=4, oScore=0, oState=IDLE; oRandNum[7:6]=0 every cycle thereafter.
- iStart; model places a number on each oLoadEnable cycle and raises iDoneLoad after 4 placements → oResetBoard high 1 cycle, oLoadEnable high until the cycle after iDoneLoad, then oShowEnable=1.
- Clicks judged correct for 1,2,3,4 → oShowEnable=0 after the first CHECK, oNumToChoose steps 1→4, WIN; oScore=4, oLevel=5.
- Clicks: correct, then wrong (both flags high) → FAIL, oStrikes=1, oLevel stays 4. After RESULT_CYCLES (set 10 in sim) → CLEAR.
- Three consecutive FAILs → oGameOver=1, oStrikes=3; a further iMouseClick gives no oMouseClick; iStart → oStrikes=0, oLevel=4, CLEAR.
- iReset asserted in WAIT, and again at oLevel=MAX_LEVEL after a WIN → immediate IDLE with reset values. With level 20 and a WIN, oLevel stays 20 and oScore=20.

Source files
------------

// File: rtl/chimp_take2_control.sv
// chimp_take2_control
// ---------------------------------------------------------------------------
// Sequencing FSM for the 8x8 chimp-test board datapath. It clears the board,
// drives the per-round load with an on-chip LFSR, shows/hides the numbers,
// forwards mouse clicks, judges each click from the datapath's flags and keeps
// level, strikes, score and game-over status.
//
// Optional feature (compile-time macro CHIMP_SHOW_TIMEOUT_EN):
//   defined   - SHOW also times out after 2*RESULT_CYCLES with no click and
//               moves to HIDE (numbers hidden, "1" still expected).
//   undefined - numbers stay visible until the first correct click.
//
// Ports:
//   clk               system clock, single domain
//   iReset            synchronous, active-high reset
//   iStart            one-cycle pulse, starts a game from IDLE or GAME_OVER
//   iMouseClick       one-cycle click pulse (box already decoded)
//   iDoneLoad         datapath: all numbers placed
//   iChoseCorrectNum  datapath correct flag (level, may be sticky)
//   iChoseWrongNum    datapath wrong flag (level, may be sticky)
//   oResetBoard       clear datapath board/flags
//   oLoadEnable       datapath may place a number this cycle
//   oShowEnable       numbers visible
//   oLevel            numbers in the current round
//   oNumToChoose      next number expected
//   oRandNum          {2'b00, row[2:0], col[2:0]} from the LFSR
//   oMouseClick       gated click forwarded to the datapath
//   oStrikes          failed rounds so far
//   oScore            highest level completed
//   oGameOver         high in GAME_OVER
//   oState            current state encoding (debug / HEX display)
//
// State encoding on oState:
//   0 IDLE, 1 CLEAR, 2 LOAD, 3 SHOW, 4 HIDE, 5 WAIT, 6 CHECK, 7 WIN,
//   8 FAIL, 9 GAME_OVER
//
// Handshake: there is no backpressure on any interface. iStart, iMouseClick
// and iDoneLoad are single-cycle pulses that are consumed only in the states
// that accept them and silently dropped elsewhere; oMouseClick is a
// single-cycle pulse the datapath must take on the cycle it is high.
// ---------------------------------------------------------------------------
module chimp_take2_control #(
    parameter int unsigned START_LEVEL   = 4,
    parameter int unsigned MAX_LEVEL     = 20,
    parameter int unsigned MAX_STRIKES   = 3,
    parameter int unsigned RESULT_CYCLES = 25000000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iMouseClick,
    input  logic       iDoneLoad,
    input  logic       iChoseCorrectNum,
    input  logic       iChoseWrongNum,
    output logic       oResetBoard,
    output logic       oLoadEnable,
    output logic       oShowEnable,
    output logic [4:0] oLevel,
    output logic [4:0] oNumToChoose,
    output logic [7:0] oRandNum,
    output logic       oMouseClick,
    output logic [1:0] oStrikes,
    output logic [4:0] oScore,
    output logic       oGameOver,
    output logic [3:0] oState
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_LOAD      = 4'd2,
        S_SHOW      = 4'd3,
        S_HIDE      = 4'd4,
        S_WAIT      = 4'd5,
        S_CHECK     = 4'd6,
        S_WIN       = 4'd7,
        S_FAIL      = 4'd8,
        S_GAME_OVER = 4'd9
    } state_t;

    localparam logic [4:0]  START_LV    = 5'(START_LEVEL);
    localparam logic [4:0]  MAX_LV      = 5'(MAX_LEVEL);
    localparam logic [1:0]  MAX_STRK    = 2'(MAX_STRIKES);
    localparam logic [24:0] HOLD_LAST   = 25'(RESULT_CYCLES - 1);

    state_t      state;
    state_t      nextState;

    logic [7:0]  lfsr;
    logic        lfsrFb;
    logic [24:0] holdCnt;
    logic        holdDone;
    logic        armed;
    logic        acceptClick;
    logic        startGame;
    logic        showExpired;
    logic [4:0]  levelUp;

    // Next values of the registered outputs
    logic        resetBoardD;
    logic        loadEnableD;
    logic        showEnableD;
    logic        mouseClickD;
    logic        gameOverD;
    logic [4:0]  levelD;
    logic [4:0]  numToChooseD;
    logic [1:0]  strikesD;
    logic [4:0]  scoreD;

    // ------------------------------------------------------------------
    // LFSR: x^8+x^6+x^5+x^4+1, free-running in every state
    // ------------------------------------------------------------------
    assign lfsrFb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (iReset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsrFb};
        end
    end

    assign oRandNum = {2'b00, lfsr[5:0]};

    // ------------------------------------------------------------------
    // Hold counter: restarts on every state change so WIN/FAIL each last
    // exactly RESULT_CYCLES cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (iReset || (nextState != state)) begin
            holdCnt <= '0;
        end else begin
            holdCnt <= holdCnt + 25'd1;
        end
    end

    assign holdDone = (holdCnt == HOLD_LAST);

`ifdef CHIMP_SHOW_TIMEOUT_EN
    // 2*RESULT_CYCLES does not fit the 25-bit hold counter, so SHOW gets its
    // own wider counter.
    localparam int unsigned SHOW_CYCLES = 2 * RESULT_CYCLES;
    localparam logic [26:0] SHOW_LAST   = 27'(SHOW_CYCLES - 1);

    logic [26:0] showCnt;

    always_ff @(posedge clk) begin
        if (iReset || (state != S_SHOW)) begin
            showCnt <= '0;
        end else begin
            showCnt <= showCnt + 27'd1;
        end
    end

    assign showExpired = (showCnt == SHOW_LAST);
`else
    assign showExpired = 1'b0;
`endif

    assign armed       = (state == S_SHOW) || (state == S_HIDE);
    // A click is eligible only once the state register already holds
    // SHOW/HIDE, so a click on the LOAD->SHOW edge is dropped.
    assign acceptClick = armed && iMouseClick;
    assign startGame   = ((state == S_IDLE) || (state == S_GAME_OVER)) && iStart;
    assign levelUp     = (oLevel >= MAX_LV) ? MAX_LV : (oLevel + 5'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (iReset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:      if (iStart) nextState = S_CLEAR;
            S_CLEAR:     nextState = S_LOAD;
            S_LOAD:      if (iDoneLoad) nextState = S_SHOW;
            S_SHOW: begin
                if (iMouseClick)      nextState = S_WAIT;
                else if (showExpired) nextState = S_HIDE;
            end
            S_HIDE:      if (iMouseClick) nextState = S_WAIT;
            S_WAIT:      nextState = S_CHECK;
            S_CHECK: begin
                // Wrong wins over correct; no flag at all is treated as a
                // failure so a missed flag update can never stall the game.
                if (iChoseWrongNum)                                 nextState = S_FAIL;
                else if (iChoseCorrectNum && (oNumToChoose == oLevel)) nextState = S_WIN;
                else if (iChoseCorrectNum)                          nextState = S_HIDE;
                else                                                nextState = S_FAIL;
            end
            S_WIN:       if (holdDone) nextState = S_CLEAR;
            S_FAIL: begin
                // oStrikes was already bumped on entry to FAIL
                if (holdDone) nextState = (oStrikes == MAX_STRK) ? S_GAME_OVER : S_CLEAR;
            end
            S_GAME_OVER: if (iStart) nextState = S_CLEAR;
            default:     nextState = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        resetBoardD  = (nextState == S_IDLE) || (nextState == S_CLEAR);
        loadEnableD  = (nextState == S_LOAD);
        gameOverD    = (nextState == S_GAME_OVER);
        mouseClickD  = acceptClick;
        levelD       = oLevel;
        numToChooseD = oNumToChoose;
        strikesD     = oStrikes;
        scoreD       = oScore;

        // Visibility is held through WAIT/CHECK so the first correct pick
        // is what hides the numbers.
        case (nextState)
            S_SHOW:          showEnableD = 1'b1;
            S_WAIT, S_CHECK: showEnableD = oShowEnable;
            default:         showEnableD = 1'b0;
        endcase

        if (startGame) begin
            levelD   = START_LV;
            strikesD = 2'd0;
            scoreD   = 5'd0;
        end

        if (state == S_CHECK) begin
            case (nextState)
                S_WIN: begin
                    scoreD = (oLevel > oScore) ? oLevel : oScore;
                    levelD = levelUp;
                end
                S_FAIL:  strikesD     = oStrikes + 2'd1;
                S_HIDE:  numToChooseD = oNumToChoose + 5'd1;
                default: ;
            endcase
        end

        if (nextState == S_CLEAR) begin
            numToChooseD = 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            oResetBoard  <= 1'b1;
            oLoadEnable  <= 1'b0;
            oShowEnable  <= 1'b0;
            oMouseClick  <= 1'b0;
            oGameOver    <= 1'b0;
            oLevel       <= START_LV;
            oNumToChoose <= 5'd1;
            oStrikes     <= 2'd0;
            oScore       <= 5'd0;
        end else begin
            oResetBoard  <= resetBoardD;
            oLoadEnable  <= loadEnableD;
            oShowEnable  <= showEnableD;
            oMouseClick  <= mouseClickD;
            oGameOver    <= gameOverD;
            oLevel       <= levelD;
            oNumToChoose <= numToChooseD;
            oStrikes     <= strikesD;
            oScore       <= scoreD;
        end
    end

    assign oState = state;

endmodule
